// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
//   - Opcode constants for every instruction the decoder recognises.
//   - Per-stage control bundles: each stage keeps only the fields that it or a
//     later stage still needs.
//   - Source-use flags produced by the decoder for hazard detection.
package pipe_ctrl_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  // EX stage: its own controls plus everything MEM and WB will need.
  // rwd is set only for lw, so it doubles as the "EX holds a load" flag.
  typedef struct packed {
    logic valid;
    logic is_r;
    logic alu_in_b;
    logic br;
    logic jp;
    logic illegal;
    logic rwe;
    logic dmwe;
    logic rwd;
  } ex_ctrl_t;

  // MEM stage: the illegal marker and the EX-only controls are dropped here.
  typedef struct packed {
    logic valid;
    logic rwe;
    logic dmwe;
    logic rwd;
  } mem_ctrl_t;

  typedef struct packed {
    logic valid;
    logic rwe;
    logic rwd;
  } wb_ctrl_t;

  // Which register fields the decode-stage instruction reads.
  typedef struct packed {
    logic rs;
    logic rt;
    logic rd;
    logic stat;
  } src_use_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder.
// Ports:
//   opcode  in   decode-stage opcode
//   rd      in   decode-stage rd field
//   ctrl    out  EX-stage control bundle (valid always 1; caller inserts bubbles)
//   dst     out  registered destination index (0 when nothing is written)
//   src     out  source-use flags for load-use detection
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW      = 5,
  parameter int REGW     = 5,
  parameter int LINK_REG = 31,
  parameter int STAT_REG = 30
) (
  input  logic [OPW-1:0]  opcode,
  input  logic [REGW-1:0] rd,
  output ex_ctrl_t        ctrl,
  output logic [REGW-1:0] dst,
  output src_use_t        src
);

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned; otherwise synthesis would infer latches.
  always_comb begin
    ctrl       = '0;
    ctrl.valid = 1'b1;
    dst        = '0;
    src        = '0;
    case (opcode)
      OPW'(OP_R): begin
        ctrl.is_r = 1'b1;
        ctrl.rwe  = 1'b1;
        dst       = rd;
        src.rs    = 1'b1;
        src.rt    = 1'b1;
      end
      OPW'(OP_J):   ctrl.jp = 1'b1;
      OPW'(OP_BNE), OPW'(OP_BLT): begin
        ctrl.br = 1'b1;
        src.rd  = 1'b1;
        src.rs  = 1'b1;
      end
      OPW'(OP_JAL): begin
        ctrl.jp  = 1'b1;
        ctrl.rwe = 1'b1;
        dst      = REGW'(LINK_REG);
      end
      OPW'(OP_JR): begin
        ctrl.jp = 1'b1;
        src.rd  = 1'b1;
      end
      OPW'(OP_ADDI): begin
        ctrl.alu_in_b = 1'b1;
        ctrl.rwe      = 1'b1;
        dst           = rd;
        src.rs        = 1'b1;
      end
      OPW'(OP_SW): begin
        ctrl.alu_in_b = 1'b1;
        ctrl.dmwe     = 1'b1;
        src.rd        = 1'b1;
        src.rs        = 1'b1;
      end
      OPW'(OP_LW): begin
        ctrl.alu_in_b = 1'b1;
        ctrl.rwe      = 1'b1;
        ctrl.rwd      = 1'b1;
        dst           = rd;
        src.rs        = 1'b1;
      end
      OPW'(OP_SETX): begin
        ctrl.rwe = 1'b1;
        dst      = REGW'(STAT_REG);
      end
      OPW'(OP_BEX): begin
        ctrl.br  = 1'b1;
        src.stat = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control: ID->EX->MEM->WB control registers with freeze, flush and
// optional load-use interlock.
// Build option: define CTRL_HAZARD_EN to enable load-use detection; without it
// stall_id simply follows ext_stall.
// Ports:
//   clock, reset            sole clock; synchronous active-high reset
//   id_valid, id_opcode,
//   id_rd, id_rs, id_rt     decode-stage instruction
//   ext_stall               freeze every stage register
//   br_taken                EX-stage redirect; squashes the decode instruction
//   stall_id                hold fetch/decode this cycle (combinational)
//   ex_*, mem_*, wb_*       per-stage control and destination outputs
module pipe_control
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW      = 5,
  parameter int REGW     = 5,
  parameter int LINK_REG = 31,
  parameter int STAT_REG = 30
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [OPW-1:0]  id_opcode,
  input  logic [REGW-1:0] id_rd,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            ext_stall,
  input  logic            br_taken,
  output logic            stall_id,
  output logic            ex_valid,
  output logic            ex_is_R,
  output logic            ex_ALUinB,
  output logic            ex_BR,
  output logic            ex_JP,
  output logic            ex_illegal,
  output logic [REGW-1:0] ex_rd,
  output logic            mem_valid,
  output logic            mem_DMWe,
  output logic            mem_Rwd,
  output logic [REGW-1:0] mem_rd,
  output logic            wb_valid,
  output logic            wb_Rwe,
  output logic            wb_Rwd,
  output logic [REGW-1:0] wb_rd
);

`ifdef CTRL_HAZARD_EN
  localparam bit hazard_en = 1'b1;
`else
  localparam bit hazard_en = 1'b0;
`endif

  ex_ctrl_t        dec_ctrl;
  logic [REGW-1:0] dec_dst;
  src_use_t        dec_src;

  ex_ctrl_t        ex_q,  ex_d;
  logic [REGW-1:0] ex_rd_q, ex_rd_d;
  mem_ctrl_t       mem_q;
  logic [REGW-1:0] mem_rd_q;
  wb_ctrl_t        wb_q;
  logic [REGW-1:0] wb_rd_q;

  logic src_match;
  logic load_use;
  logic bubble;

  ctrl_decode #(
    .OPW      (OPW),
    .REGW     (REGW),
    .LINK_REG (LINK_REG),
    .STAT_REG (STAT_REG)
  ) u_decode (
    .opcode (id_opcode),
    .rd     (id_rd),
    .ctrl   (dec_ctrl),
    .dst    (dec_dst),
    .src    (dec_src)
  );

  // Load-use: a load in EX whose destination the decode instruction reads.
  // A load to r0 never matches because ex_rd_q must be nonzero.
  always_comb begin
    src_match = (dec_src.rs   && (id_rs   == ex_rd_q)) ||
                (dec_src.rt   && (id_rt   == ex_rd_q)) ||
                (dec_src.rd   && (id_rd   == ex_rd_q)) ||
                (dec_src.stat && (ex_rd_q == REGW'(STAT_REG)));
    load_use  = hazard_en && id_valid && ex_q.valid && ex_q.rwd &&
                (ex_rd_q != '0) && src_match;
  end

  // The flush squashes the decode instruction, so a stall would be pointless
  // when both occur together.
  assign stall_id = !reset && (ext_stall || (!br_taken && load_use));

  always_comb begin
    bubble  = !id_valid || br_taken || load_use;
    ex_d    = bubble ? '0 : dec_ctrl;
    ex_rd_d = bubble ? '0 : dec_dst;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse the pipe.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q     <= '0;
      ex_rd_q  <= '0;
      mem_q    <= '0;
      mem_rd_q <= '0;
      wb_q     <= '0;
      wb_rd_q  <= '0;
    end else if (!ext_stall) begin
      ex_q       <= ex_d;
      ex_rd_q    <= ex_rd_d;
      mem_q.valid <= ex_q.valid;
      mem_q.rwe   <= ex_q.rwe;
      mem_q.dmwe  <= ex_q.dmwe;
      mem_q.rwd   <= ex_q.rwd;
      mem_rd_q    <= ex_rd_q;
      wb_q.valid  <= mem_q.valid;
      wb_q.rwe    <= mem_q.rwe;
      wb_q.rwd    <= mem_q.rwd;
      wb_rd_q     <= mem_rd_q;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_is_R    = ex_q.is_r;
  assign ex_ALUinB  = ex_q.alu_in_b;
  assign ex_BR      = ex_q.br;
  assign ex_JP      = ex_q.jp;
  assign ex_illegal = ex_q.illegal;
  assign ex_rd      = ex_rd_q;
  assign mem_valid  = mem_q.valid;
  assign mem_DMWe   = mem_q.dmwe;
  assign mem_Rwd    = mem_q.rwd;
  assign mem_rd     = mem_rd_q;
  assign wb_valid   = wb_q.valid;
  assign wb_Rwe     = wb_q.rwe;
  assign wb_Rwd     = wb_q.rwd;
  assign wb_rd      = wb_rd_q;

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control. Retiring instructions are checked in
// order against a scoreboard; each scenario task checks its own stage outputs.
module tb_pipe_control;
  import pipe_ctrl_pkg::*;

`ifdef CTRL_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_opcode = '0;
  logic [4:0] id_rd = '0, id_rs = '0, id_rt = '0;
  logic       ext_stall = 1'b0;
  logic       br_taken = 1'b0;
  logic       stall_id;
  logic       ex_valid, ex_is_R, ex_ALUinB, ex_BR, ex_JP, ex_illegal;
  logic [4:0] ex_rd;
  logic       mem_valid, mem_DMWe, mem_Rwd;
  logic [4:0] mem_rd;
  logic       wb_valid, wb_Rwe, wb_Rwd;
  logic [4:0] wb_rd;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       rwe;
    logic       rwd;
    logic [4:0] rd;
  } wb_exp_t;

  wb_exp_t sb[$];

  always #5 clock = ~clock;

  pipe_control dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt), .ext_stall(ext_stall),
    .br_taken(br_taken), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_is_R(ex_is_R), .ex_ALUinB(ex_ALUinB),
    .ex_BR(ex_BR), .ex_JP(ex_JP), .ex_illegal(ex_illegal), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_DMWe(mem_DMWe), .mem_Rwd(mem_Rwd),
    .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_Rwe(wb_Rwe), .wb_Rwd(wb_Rwd),
    .wb_rd(wb_rd)
  );

  logic [26:0] all_out;
  assign all_out = {ex_valid, ex_is_R, ex_ALUinB, ex_BR, ex_JP, ex_illegal, ex_rd,
                    mem_valid, mem_DMWe, mem_Rwd, mem_rd,
                    wb_valid, wb_Rwe, wb_Rwd, wb_rd};

  // Expected write-back effect of an accepted instruction.
  function automatic wb_exp_t model_wb(logic [4:0] op, logic [4:0] rd);
    wb_exp_t e = '0;
    case (op)
      OP_R, OP_ADDI: begin e.rwe = 1'b1; e.rd = rd; end
      OP_LW:         begin e.rwe = 1'b1; e.rwd = 1'b1; e.rd = rd; end
      OP_JAL:        begin e.rwe = 1'b1; e.rd = 5'd31; end
      OP_SETX:       begin e.rwe = 1'b1; e.rd = 5'd30; end
      default:       ;
    endcase
    return e;
  endfunction

  // Retirement monitor: one comparison per instruction newly arriving in WB.
  always @(posedge clock) begin : wb_monitor
    logic held;
    wb_exp_t e;
    held = ext_stall && !reset;
    #2;
    if (!held && wb_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected got rwe=%0b rwd=%0b rd=%0d required no retirement",
                 wb_Rwe, wb_Rwd, wb_rd);
      end else begin
        e = sb.pop_front();
        if ({wb_Rwe, wb_Rwd, wb_rd} !== {e.rwe, e.rwd, e.rd}) begin
          failures++;
          $display("FAIL wb_retire got rwe=%0b rwd=%0b rd=%0d required rwe=%0b rwd=%0b rd=%0d",
                   wb_Rwe, wb_Rwd, wb_rd, e.rwe, e.rwd, e.rd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt);
    id_valid  = 1'b1;
    id_opcode = op;
    id_rd     = rd;
    id_rs     = rs;
    id_rt     = rt;
  endtask

  task automatic idle();
    id_valid  = 1'b0;
    id_opcode = '0;
    id_rd     = '0;
    id_rs     = '0;
    id_rt     = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ext_stall = 1'b1;
    drive(OP_LW, 5'd4, 5'd1, 5'd2);
    tick();
    tick();
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", all_out);
    end
    checks++;
    if (stall_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall_id got=%b required=0", stall_id);
    end
    reset = 1'b0;
    ext_stall = 1'b0;
    idle();
    sb.delete();
    tick();
  endtask

  task automatic test_addi();
    drive(OP_ADDI, 5'd3, 5'd1, 5'd2);
    tick();
    sb.push_back(model_wb(OP_ADDI, 5'd3));
    idle();
    checks++;
    if ({ex_valid, ex_ALUinB, ex_is_R, ex_rd} !== {1'b1, 1'b1, 1'b0, 5'd3}) begin
      failures++;
      $display("FAIL addi_ex got v=%b alub=%b isr=%b rd=%0d required 1 1 0 3",
               ex_valid, ex_ALUinB, ex_is_R, ex_rd);
    end
    tick();
    checks++;
    if ({mem_valid, mem_rd} !== {1'b1, 5'd3}) begin
      failures++;
      $display("FAIL addi_mem got v=%b rd=%0d required 1 3", mem_valid, mem_rd);
    end
    tick();
    checks++;
    if ({wb_valid, wb_Rwe, wb_Rwd, wb_rd} !== {1'b1, 1'b1, 1'b0, 5'd3}) begin
      failures++;
      $display("FAIL addi_wb got v=%b rwe=%b rwd=%b rd=%0d required 1 1 0 3",
               wb_valid, wb_Rwe, wb_Rwd, wb_rd);
    end
    tick();
  endtask

  task automatic test_decode();
    logic [4:0] ops [12];
    logic [9:0] exp_ex [12];  // {is_R, ALUinB, BR, JP, illegal, rd}
    ops    = '{OP_R, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI,
               OP_BLT, OP_SW, OP_LW, OP_SETX, OP_BEX, 5'b01001};
    exp_ex = '{{5'b10000, 5'd7}, {5'b00010, 5'd0}, {5'b00100, 5'd0},
               {5'b00010, 5'd31}, {5'b00010, 5'd0}, {5'b01000, 5'd7},
               {5'b00100, 5'd0}, {5'b01000, 5'd0}, {5'b01000, 5'd7},
               {5'b00000, 5'd30}, {5'b00100, 5'd0}, {5'b00001, 5'd0}};
    for (int i = 0; i < 12; i++) begin
      drive(ops[i], 5'd7, 5'd1, 5'd2);
      tick();
      sb.push_back(model_wb(ops[i], 5'd7));
      idle();
      checks++;
      if ({ex_valid, ex_is_R, ex_ALUinB, ex_BR, ex_JP, ex_illegal, ex_rd} !==
          {1'b1, exp_ex[i]}) begin
        failures++;
        $display("FAIL decode_ex op=%b got=%b required=%b", ops[i],
                 {ex_valid, ex_is_R, ex_ALUinB, ex_BR, ex_JP, ex_illegal, ex_rd},
                 {1'b1, exp_ex[i]});
      end
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic test_load_use();
    // lw r5 followed by add reading r5 through rs.
    drive(OP_LW, 5'd5, 5'd1, 5'd2);
    tick();
    sb.push_back(model_wb(OP_LW, 5'd5));
    drive(OP_R, 5'd9, 5'd5, 5'd2);
    #1;
    checks++;
    if (stall_id !== HAZ) begin
      failures++;
      $display("FAIL loaduse_stall got=%b required=%b", stall_id, HAZ);
    end
    tick();
    if (!HAZ) begin
      sb.push_back(model_wb(OP_R, 5'd9));
      idle();
    end
    checks++;
    if ({ex_valid, ex_is_R} !== {~HAZ, ~HAZ}) begin
      failures++;
      $display("FAIL loaduse_bubble got v=%b isr=%b required %b %b",
               ex_valid, ex_is_R, ~HAZ, ~HAZ);
    end
    checks++;
    if (stall_id !== 1'b0) begin
      failures++;
      $display("FAIL loaduse_stall_once got=%b required=0", stall_id);
    end
    tick();
    if (HAZ) begin
      sb.push_back(model_wb(OP_R, 5'd9));
      idle();
    end
    checks++;
    if ({ex_valid, ex_is_R, ex_rd} !== {HAZ, HAZ, HAZ ? 5'd9 : 5'd0}) begin
      failures++;
      $display("FAIL loaduse_late_ex got v=%b isr=%b rd=%0d required %b %b %0d",
               ex_valid, ex_is_R, ex_rd, HAZ, HAZ, HAZ ? 9 : 0);
    end
    repeat (3) tick();

    // lw r0 followed by add reading r0 never stalls.
    drive(OP_LW, 5'd0, 5'd1, 5'd2);
    tick();
    sb.push_back(model_wb(OP_LW, 5'd0));
    drive(OP_R, 5'd9, 5'd0, 5'd0);
    #1;
    checks++;
    if (stall_id !== 1'b0) begin
      failures++;
      $display("FAIL loaduse_r0 got=%b required=0", stall_id);
    end
    tick();
    sb.push_back(model_wb(OP_R, 5'd9));
    idle();
    checks++;
    if ({ex_valid, ex_is_R} !== 2'b11) begin
      failures++;
      $display("FAIL loaduse_r0_ex got v=%b isr=%b required 1 1", ex_valid, ex_is_R);
    end
    repeat (3) tick();

    // lw into the status register followed by bex.
    drive(OP_LW, 5'd30, 5'd1, 5'd2);
    tick();
    sb.push_back(model_wb(OP_LW, 5'd30));
    drive(OP_BEX, 5'd0, 5'd0, 5'd0);
    #1;
    checks++;
    if (stall_id !== HAZ) begin
      failures++;
      $display("FAIL loaduse_bex got=%b required=%b", stall_id, HAZ);
    end
    tick();
    if (HAZ) tick();
    sb.push_back(model_wb(OP_BEX, 5'd0));
    idle();
    checks++;
    if ({ex_valid, ex_BR} !== 2'b11) begin
      failures++;
      $display("FAIL loaduse_bex_ex got v=%b br=%b required 1 1", ex_valid, ex_BR);
    end
    repeat (3) tick();
  endtask

  task automatic test_flush();
    drive(OP_SW, 5'd4, 5'd1, 5'd2);
    br_taken = 1'b1;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall got=%b required=0", stall_id);
    end
    tick();
    br_taken = 1'b0;
    idle();
    checks++;
    if ({ex_valid, ex_ALUinB, ex_rd} !== 7'b0) begin
      failures++;
      $display("FAIL flush_bubble got v=%b alub=%b rd=%0d required 0 0 0",
               ex_valid, ex_ALUinB, ex_rd);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_DMWe !== 1'b0) begin
        failures++;
        $display("FAIL flush_dmwe cycle=%0d got=%b required=0", i, mem_DMWe);
      end
    end

    // Flush and load-use together: flush wins, the load still advances.
    drive(OP_LW, 5'd5, 5'd1, 5'd2);
    tick();
    sb.push_back(model_wb(OP_LW, 5'd5));
    drive(OP_R, 5'd9, 5'd5, 5'd2);
    br_taken = 1'b1;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin
      failures++;
      $display("FAIL flush_vs_hazard_stall got=%b required=0", stall_id);
    end
    tick();
    br_taken = 1'b0;
    idle();
    checks++;
    if ({ex_valid, mem_valid, mem_Rwd, mem_rd} !== {1'b0, 1'b1, 1'b1, 5'd5}) begin
      failures++;
      $display("FAIL flush_vs_hazard_pipe got exv=%b memv=%b rwd=%b rd=%0d required 0 1 1 5",
               ex_valid, mem_valid, mem_Rwd, mem_rd);
    end
    repeat (3) tick();
  endtask

  task automatic test_ext_stall();
    logic [26:0] frozen;
    drive(OP_ADDI, 5'd1, 5'd6, 5'd0);
    tick();
    sb.push_back(model_wb(OP_ADDI, 5'd1));
    drive(OP_R, 5'd2, 5'd4, 5'd5);
    tick();
    sb.push_back(model_wb(OP_R, 5'd2));
    drive(OP_LW, 5'd3, 5'd7, 5'd0);
    tick();
    sb.push_back(model_wb(OP_LW, 5'd3));
    idle();
    // EX=lw r3, MEM=add r2, WB=addi r1.
    frozen = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3,
              1'b1, 1'b0, 1'b0, 5'd2,
              1'b1, 1'b1, 1'b0, 5'd1};
    ext_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (stall_id !== 1'b1) begin
        failures++;
        $display("FAIL ext_stall_id cycle=%0d got=%b required=1", i, stall_id);
      end
      tick();
      checks++;
      if (all_out !== frozen) begin
        failures++;
        $display("FAIL ext_stall_hold cycle=%0d got=%h required=%h", i, all_out, frozen);
      end
    end
    ext_stall = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_illegal();
    drive(5'b11111, 5'd6, 5'd1, 5'd2);
    tick();
    sb.push_back(model_wb(5'b11111, 5'd6));
    idle();
    checks++;
    if ({ex_valid, ex_illegal, ex_rd} !== {1'b1, 1'b1, 5'd0}) begin
      failures++;
      $display("FAIL illegal_ex got v=%b ill=%b rd=%0d required 1 1 0",
               ex_valid, ex_illegal, ex_rd);
    end
    tick();
    checks++;
    if (ex_illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_once got=%b required=0", ex_illegal);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(OP_LW, 5'd2, 5'd1, 5'd0);
    tick();
    drive(OP_ADDI, 5'd4, 5'd1, 5'd0);
    tick();
    idle();
    ext_stall = 1'b1;
    tick();
    reset = 1'b1;
    sb.delete();
    tick();
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_mid_stall got=%h required=0", all_out);
    end
    checks++;
    if (stall_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_stall_id got=%b required=0", stall_id);
    end
    reset = 1'b0;
    ext_stall = 1'b0;
    repeat (3) tick();
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_discard got=%h required=0", all_out);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_decode();
    test_load_use();
    test_flush();
    test_ext_stall();
    test_illegal();
    test_reset_mid_stall();
    repeat (4) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameters SHALL be: OPW, default 5, opcode width; REGW, default 5, register-index width; LINK_REG, default 31, jal destination; STAT_REG, default 30, setx destination.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  decode-stage instruction present.
REQ-005 id_opcode  input  OPW  decode-stage opcode.
REQ-006 id_rd, id_rs, id_rt  input  REGW each  decode-stage register fields.
REQ-007 ext_stall  input  1  global freeze request (for example, a memory wait).
REQ-008 br_taken  input  1  EX-stage redirect (taken branch or jump); flushes the decode stage.
REQ-009 stall_id  output  1  combinational; hold the fetch and decode registers this cycle.
REQ-010 ex_valid, ex_is_R, ex_ALUinB, ex_BR, ex_JP, ex_illegal  output  1 each  EX-stage control; ex_rd output REGW.
REQ-011 mem_valid, mem_DMWe, mem_Rwd  output  1 each  MEM-stage control; mem_rd output REGW.
REQ-012 wb_valid, wb_Rwe, wb_Rwd  output  1 each  WB-stage control; wb_rd output REGW.

Function
REQ-013 Decoding SHALL cover opcodes R=00000, j=00001, bne=00010, jal=00011, jr=00100, addi=00101, blt=00110, sw=00111, lw=01000, setx=10101, bex=10110; every other opcode is illegal.
REQ-014 Rwe SHALL be asserted for R, addi, lw, jal and setx; DMWe only for sw; Rwd only for lw; ALUinB for addi, lw and sw.
REQ-015 BR SHALL be asserted for bne, blt and bex; JP for j, jal and jr.
REQ-016 The registered destination SHALL be: id_rd for R, addi and lw; LINK_REG for jal; STAT_REG for setx; 0 otherwise.
REQ-017 Source-use SHALL be decoded as follows: R reads rs and rt; addi and lw read rs; sw, bne and blt read rd and rs; jr reads rd; bex reads STAT_REG.
REQ-018 Control SHALL be registered in three stages, with latency from ID to EX of 1 cycle, to MEM of 2 cycles and to WB of 3 cycles.
REQ-019 Each stage SHALL carry only the fields that later stages use.
REQ-020 An illegal opcode with id_valid=1 SHALL enter EX with ex_illegal=1, all write enables 0 and ex_valid=1.
REQ-021 The ex_illegal marker SHALL NOT propagate beyond EX.
REQ-022 Priority SHALL be: reset > ext_stall > br_taken > load-use stall.
REQ-023 When ext_stall=1, all stage registers SHALL hold their values and stall_id SHALL be 1.
REQ-024 When br_taken=1, EX SHALL load a bubble (valid and all controls 0) while MEM and WB advance normally; stall_id SHALL be 0.
REQ-025 A load-use hazard exists when ex_valid=1, the EX instruction is lw, ex_rd≠0, and ex_rd equals any source register the ID instruction reads.
REQ-026 On a load-use hazard, stall_id SHALL be 1, EX SHALL load a bubble, and MEM and WB SHALL advance.
REQ-027 Source register 0 SHALL never cause a hazard.
REQ-028 When id_valid=0, EX SHALL load a bubble.
REQ-029 A bubble SHALL carry rd=0.
REQ-030 When br_taken and a load-use hazard occur in the same cycle, the flush SHALL win and stall_id SHALL be 0.

Reset
REQ-031 When reset is asserted, all valid bits, control bits and rd fields SHALL be 0 on the next edge.
REQ-032 stall_id SHALL be 0 while reset is asserted.
REQ-033 Reset asserted mid-stall SHALL discard all in-flight instructions.

Configuration
REQ-034 With CTRL_HAZARD_EN defined, the load-use detection of REQ-025 to REQ-027 and REQ-030 SHALL be present.
REQ-035 Without CTRL_HAZARD_EN, stall_id SHALL equal ext_stall and no bubble SHALL be inserted for load-use.

Structure
REQ-036 A shared package pipe_ctrl_pkg SHALL hold the opcode constants and the per-stage control-bundle struct typedefs.
REQ-037 One sub-module, ctrl_decode, SHALL perform the purely combinational opcode-to-bundle decode, including source-use flags.
REQ-038 pipe_control SHALL hold the stage registers and the hazard/flush logic.

Verification
REQ-039 Issue addi r3 (opcode 00101, rd=3) -> ex_ALUinB=1 after 1 cycle; wb_Rwe=1 and wb_rd=3 after 3 cycles; wb_Rwd=0.
REQ-040 Issue lw r5 followed immediately by add with rs=5 -> stall_id=1 for exactly 1 cycle, one bubble in EX, and the add reaches EX 1 cycle late.
REQ-041 Issue lw r0 followed by add with rs=0 -> no stall.
REQ-042 Assert br_taken while a sw sits in ID -> EX becomes a bubble and mem_DMWe is never 1 for that sw.
REQ-043 Hold ext_stall=1 for 4 cycles with three valid instructions in flight -> all outputs are constant, then resume in order.
REQ-044 Issue opcode 11111 -> ex_illegal=1 for 1 cycle; wb_Rwe=0; after reset, all outputs are 0.
